iact_fifo: RTL and testbench
============================

# iact_fifo

Synchronous FIFO that holds input-activation (iact) words between the iact source and the PE scratchpad read side. It produces the `full` and `empty` status that drives `BufferController`. Writes are qualified by the controller's `ready`, and reads are issued by the PE consumer. One clock domain, registered read data, and status flags that exactly reflect the pointer state.

## Interface
Parameters:
- `DATA_W`, 16, iact word width
- `DEPTH`, 16, number of entries; must be a power of two, ≥2
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  write request; the caller has already ANDed it with the controller's `ready`
- `wr_data`  in  DATA_W  word to write
- `rd_en`  in  1  read request from the PE consumer
- `rd_data`  out  DATA_W  registered read word
- `rd_valid`  out  1  `rd_data` holds a word popped on the previous cycle
- `full`  out  1  DEPTH entries stored
- `empty`  out  1  zero entries stored
- `count`  out  AW+1  occupancy, 0..DEPTH (`IACT_FIFO_STATUS_EN` only)
- `ovf`  out  1  sticky: write attempted while full (`IACT_FIFO_STATUS_EN` only)
- `udf`  out  1  sticky: read attempted while empty (`IACT_FIFO_STATUS_EN` only)

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are AW+1 bits. The low AW bits index storage; the MSB is the wrap bit.
- `empty` = (`wr_ptr` == `rd_ptr`).
- `full` = low bits equal and MSBs differ.
- Both flags are combinational from registered pointers, so they are glitch-free relative to `clk`.
- Accepted write: `wr_en && !full`. Stores `wr_data` at `wr_ptr[AW-1:0]`, then increments `wr_ptr` modulo 2^(AW+1).
- Accepted read: `rd_en && !empty`. Loads `mem[rd_ptr[AW-1:0]]` into `rd_data`, increments `rd_ptr`, and sets `rd_valid`=1 on the next cycle. Otherwise `rd_valid`=0 next cycle and `rd_data` holds its value.
- Full boundary: a write while full is dropped, even if a read is accepted the same cycle. Full + write + read gives one pop and no push, so `count` goes DEPTH→DEPTH-1.
- Empty boundary: a read while empty is dropped, even with a same-cycle write. No fall-through: the word becomes readable the cycle after it is written.
- Simultaneous accepted read and write when neither flag is set: both pointers advance and occupancy is unchanged.
- Wrap-around: pointer increment is natural overflow of AW+1 bits. No special case is needed.
- Memory contents are never reset. Only pointers and outputs are reset.

## Timing
Reset values, asynchronous on `rstn`=0:
- `wr_ptr`=0, `rd_ptr`=0
- `rd_data`=0, `rd_valid`=0
- `empty`=1, `full`=0
- `count`=0, `ovf`=0, `udf`=0

Reset behaviour:
- Reset mid-operation discards all stored words. The FIFO is empty the cycle `rstn` is sampled high.
- The first accepted write after reset is the first word read.

Latencies:
- Write-to-`empty` deassert: `empty` falls 1 cycle after the first accepted write edge.
- Read latency: `rd_data`/`rd_valid` valid 1 cycle after the `rd_en` edge.
- `full` rises on the edge of the DEPTH-th un-popped write. It falls on the edge of the first accepted read thereafter.

## Configuration
- `IACT_FIFO_STATUS_EN` defined:
  - `count` = `wr_ptr` − `rd_ptr` (AW+1 bits, modular).
  - `ovf` sets on `wr_en && full`; `udf` sets on `rd_en && empty`.
  - Both are sticky until reset.
- `IACT_FIFO_STATUS_EN` undefined: `count`, `ovf` and `udf` ports and their logic are absent. FIFO behaviour is otherwise identical.

## Structure
- Shared package `eyeriss_pkg`:
  - `IACT_W` (16) and `IACT_FIFO_DEPTH` (16) constants, used as parameter defaults at instantiation.
  - `iact_t` typedef (`logic [IACT_W-1:0]`).
- Sub-module `fifo_mem`: a DEPTH×DATA_W register array with one synchronous write port and one registered read port.
  - Pointer/flag logic stays in `iact_fifo`.
  - No other sub-modules.

## Test plan
- Reset, then write 0x0001..0x0010 (DEPTH=16) on consecutive cycles → `full`=1 after the 16th edge, `empty`=0; a 17th write of 0xDEAD is dropped (`ovf`=1 with macro).
- Read 16 times from full → `rd_data` returns 0x0001..0x0010 in order with `rd_valid`=1 each cycle; `empty`=1 after the last pop; an extra `rd_en` gives `rd_valid`=0 (`udf`=1 with macro).
- At 8 entries, assert `wr_en` and `rd_en` for 40 cycles → `count` stays 8, pointers wrap twice, data order is preserved.
- Full + simultaneous `wr_en`/`rd_en` → one word popped, write dropped, `full`=0, `count`=15. Empty + simultaneous `wr_en`/`rd_en` → read dropped (`rd_valid`=0), `count`=1.
- Assert `rstn`=0 asynchronously with 5 entries stored, mid-cycle → `empty`=1 and `rd_valid`=0 immediately; after release, write 0x00AA and read → `rd_data`=0x00AA.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared constants and types for the Eyeriss-style datapath.
// Supplies the default iact word width and iact FIFO depth.
package eyeriss_pkg;

   localparam int IACT_W          = 16;
   localparam int IACT_FIFO_DEPTH = 16;

   typedef logic [IACT_W-1:0] iact_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
// Contents are never reset; only the read register is.
module fifo_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register holds its value when no read is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/iact_fifo.sv
// Synchronous iact FIFO between the iact source and the PE scratchpad read side.
// Define IACT_FIFO_STATUS_EN to add the count/ovf/udf status ports.
module iact_fifo
   import eyeriss_pkg::*;
#(
   parameter int DATA_W = IACT_W,
   parameter int DEPTH  = IACT_FIFO_DEPTH,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
`ifdef IACT_FIFO_STATUS_EN
   output logic              empty,
   output logic [AW:0]       count,
   output logic              ovf,
   output logic              udf
`else
   output logic              empty
`endif
);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        wr_ok;
   logic        rd_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         rd_valid <= rd_ok;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

`ifdef IACT_FIFO_STATUS_EN
   assign count = wr_ptr - rd_ptr;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wr_en && full) begin
            ovf <= 1'b1;
         end
         if (rd_en && empty) begin
            udf <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_iact_fifo.sv
// Scoreboard testbench for iact_fifo: accepted writes are queued, accepted reads pop and compare.
// Status-port checks are compiled in when IACT_FIFO_STATUS_EN is defined.
module tb_iact_fifo;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 16;
   localparam int AW     = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rd_en = 1'b0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
`ifdef IACT_FIFO_STATUS_EN
   logic [AW:0]       count;
   logic              ovf;
   logic              udf;
`endif

   iact_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
`ifdef IACT_FIFO_STATUS_EN
      .empty    (empty),
      .count    (count),
      .ovf      (ovf),
      .udf      (udf)
`else
      .empty    (empty)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard / reference model state
   logic [DATA_W-1:0] wq[$];
   int                mcount = 0;
   logic              exp_valid = 1'b0;
   logic [DATA_W-1:0] exp_data = '0;
   logic              m_ovf = 1'b0;
   logic              m_udf = 1'b0;
   int                passed = 0;
   int                total = 0;

   // Drives one cycle starting at a negedge and returns at the following negedge.
   task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic r);
      logic wacc;
      logic racc;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      @(posedge clk);
      wacc = w && (mcount < DEPTH);
      racc = r && (mcount > 0);
      if (w && mcount == DEPTH) m_ovf = 1'b1;
      if (r && mcount == 0) m_udf = 1'b1;
      exp_valid = racc;
      if (racc) exp_data = wq.pop_front();
      if (wacc) wq.push_back(d);
      mcount = mcount + int'(wacc) - int'(racc);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic model_reset();
      wq.delete();
      mcount    = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: empty=%b full=%b required empty=1 full=0", empty, full);
      else passed++;
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h0000) $display("FAIL reset_rd: rd_valid=%b rd_data=%h required 0/0000", rd_valid, rd_data);
      else passed++;
`ifdef IACT_FIFO_STATUS_EN
      total++;
      if (count !== '0 || ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_status: count=%0d ovf=%b udf=%b required 0/0/0", count, ovf, udf);
      else passed++;
`endif
      $display("reset: empty=%b full=%b rd_valid=%b", empty, full, rd_valid);
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1'b1, DATA_W'(i), 1'b0);
         total++;
         if (empty !== 1'b0 || full !== (mcount == DEPTH)) $display("FAIL fill_flags: write %0d empty=%b full=%b required empty=0 full=%b", i, empty, full, mcount == DEPTH);
         else passed++;
         $display("fill: wrote %h empty=%b full=%b", DATA_W'(i), empty, full);
      end
      drive(1'b1, 16'hDEAD, 1'b0);
      total++;
      if (full !== 1'b1 || empty !== 1'b0) $display("FAIL overflow_flags: full=%b empty=%b required 1/0", full, empty);
      else passed++;
`ifdef IACT_FIFO_STATUS_EN
      total++;
      if (ovf !== m_ovf || count !== (AW+1)'(mcount)) $display("FAIL overflow_status: ovf=%b count=%0d required %b/%0d", ovf, count, m_ovf, mcount);
      else passed++;
`endif
      $display("fill: dropped DEAD while full, full=%b", full);
   endtask

   task automatic test_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1'b0, '0, 1'b1);
         total++;
         if (rd_valid !== exp_valid || rd_data !== exp_data) $display("FAIL drain_data: read %0d rd_valid=%b rd_data=%h required %b/%h", i, rd_valid, rd_data, exp_valid, exp_data);
         else passed++;
         total++;
         if (empty !== (mcount == 0) || full !== 1'b0) $display("FAIL drain_flags: read %0d empty=%b full=%b required %b/0", i, empty, full, mcount == 0);
         else passed++;
         $display("drain: rd_valid=%b rd_data=%h empty=%b", rd_valid, rd_data, empty);
      end
      drive(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b0 || rd_data !== exp_data || empty !== 1'b1) $display("FAIL underflow: rd_valid=%b rd_data=%h empty=%b required 0/%h/1", rd_valid, rd_data, empty, exp_data);
      else passed++;
`ifdef IACT_FIFO_STATUS_EN
      total++;
      if (udf !== m_udf) $display("FAIL underflow_status: udf=%b required %b", udf, m_udf);
      else passed++;
`endif
      $display("drain: extra read on empty rd_valid=%b", rd_valid);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) drive(1'b1, 16'h0100 + DATA_W'(i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 16'h0200 + DATA_W'(i), 1'b1);
         total++;
         if (rd_valid !== exp_valid || rd_data !== exp_data) $display("FAIL b2b_data: cycle %0d rd_valid=%b rd_data=%h required %b/%h", i, rd_valid, rd_data, exp_valid, exp_data);
         else passed++;
         total++;
         if (full !== 1'b0 || empty !== 1'b0) $display("FAIL b2b_flags: cycle %0d full=%b empty=%b required 0/0", i, full, empty);
         else passed++;
`ifdef IACT_FIFO_STATUS_EN
         total++;
         if (count !== 5'd8) $display("FAIL b2b_count: cycle %0d count=%0d required 8", i, count);
         else passed++;
`endif
         $display("b2b: cycle %0d rd_data=%h rd_valid=%b", i, rd_data, rd_valid);
      end
   endtask

   task automatic test_boundaries();
      while (mcount < DEPTH) drive(1'b1, 16'h0300 + DATA_W'(mcount), 1'b0);
      drive(1'b1, 16'hBEEF, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_data || full !== 1'b0) $display("FAIL full_rw: rd_valid=%b rd_data=%h full=%b required 1/%h/0", rd_valid, rd_data, full, exp_data);
      else passed++;
`ifdef IACT_FIFO_STATUS_EN
      total++;
      if (count !== 5'd15) $display("FAIL full_rw_count: count=%0d required 15", count);
      else passed++;
`endif
      $display("boundary: full + rd/wr popped %h full=%b", rd_data, full);
      while (mcount > 0) begin
         drive(1'b0, '0, 1'b1);
         total++;
         if (rd_valid !== 1'b1 || rd_data !== exp_data) $display("FAIL bnd_drain: rd_valid=%b rd_data=%h required 1/%h", rd_valid, rd_data, exp_data);
         else passed++;
      end
      drive(1'b1, 16'h0055, 1'b1);
      total++;
      if (rd_valid !== 1'b0 || empty !== 1'b0 || full !== 1'b0) $display("FAIL empty_rw: rd_valid=%b empty=%b full=%b required 0/0/0", rd_valid, empty, full);
      else passed++;
`ifdef IACT_FIFO_STATUS_EN
      total++;
      if (count !== 5'd1) $display("FAIL empty_rw_count: count=%0d required 1", count);
      else passed++;
`endif
      $display("boundary: empty + rd/wr rd_valid=%b empty=%b", rd_valid, empty);
      drive(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h0055) $display("FAIL empty_rw_read: rd_valid=%b rd_data=%h required 1/0055", rd_valid, rd_data);
      else passed++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 16'h0400 + DATA_W'(i), 1'b0);
      drive(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_data) $display("FAIL pre_reset_read: rd_valid=%b rd_data=%h required 1/%h", rd_valid, rd_data, exp_data);
      else passed++;
      #2 rstn = 1'b0;
      #1;
      model_reset();
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000) $display("FAIL async_reset: empty=%b full=%b rd_valid=%b rd_data=%h required 1/0/0/0000", empty, full, rd_valid, rd_data);
      else passed++;
      $display("async_reset: empty=%b rd_valid=%b", empty, rd_valid);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      drive(1'b1, 16'h00AA, 1'b0);
      drive(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h00AA || exp_data !== 16'h00AA) $display("FAIL post_reset_read: rd_valid=%b rd_data=%h required 1/00aa", rd_valid, rd_data);
      else passed++;
      $display("async_reset: post-reset read rd_data=%h", rd_data);
   endtask

   initial begin
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rstn = 1'b1;
      @(negedge clk);
      test_fill();
      test_drain();
      test_back_to_back();
      test_boundaries();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1);
   end

endmodule
